// File: rtl/arb_pkg.sv
// arb_pkg: shared constants, FSM encoding and round-robin pick for the 8-way arbiter
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int CODE_W = 3;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
  // Returns {found, idx}: first set req bit scanning upward from last+1, wrapping, with last itself checked last
  function automatic logic [CODE_W:0] rr_pick(input logic [N_REQ-1:0] req, input logic [CODE_W-1:0] last);
    logic [CODE_W:0] r;
    logic [CODE_W-1:0] idx;
    r = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = last + CODE_W'(i);
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction
endpackage

// File: rtl/decoder_3_8.sv
// decoder_3_8: 3-bit binary code to 8-bit one-hot
module decoder_3_8 (
  input  logic [2:0] code_in,
  output logic [7:0] code_out
);
  assign code_out = 8'd1 << code_in;
endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: round-robin arbiter for 8 requesters with optional maximum hold time
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  grant,
  output logic [CODE_W-1:0] grant_code,
  output logic              grant_valid
);
  localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  state_t state, state_nxt;
  logic [CODE_W-1:0] last, last_nxt, code_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [CODE_W:0] pick;
  logic [N_REQ-1:0] dec;
  logic owner_req, expired;
  assign pick = rr_pick(req, last);
  assign owner_req = req[grant_code];
  assign expired = (MAX_HOLD != 0) && (int'(hold_cnt) >= MAX_HOLD - 1);
  assign grant_valid = (state == GRANT);
  assign grant = dec & {N_REQ{grant_valid}};
  decoder_3_8 u_dec (
    .code_in (grant_code),
    .code_out(dec)
  );
  // Next state: grant from idle, hold, or hand over (release and timeout both re-arbitrate; last == owner here)
  always_comb begin
    state_nxt = state;
    code_nxt = grant_code;
    last_nxt = last;
    hold_nxt = hold_cnt;
    if (state == IDLE || !owner_req || expired) begin
      state_nxt = pick[CODE_W] ? GRANT : IDLE;
      code_nxt = pick[CODE_W] ? pick[CODE_W-1:0] : grant_code;
      last_nxt = pick[CODE_W] ? pick[CODE_W-1:0] : last;
      hold_nxt = '0;
    end else begin
      hold_nxt = (&hold_cnt) ? hold_cnt : hold_cnt + 1'b1;
    end
  end
  // State, owner, pointer and hold counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant_code <= '0;
      last <= CODE_W'(N_REQ - 1);
      hold_cnt <= '0;
    end else begin
      state <= state_nxt;
      grant_code <= code_nxt;
      last <= last_nxt;
      hold_cnt <= hold_nxt;
    end
  end
endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: scoreboard bench comparing the arbiter against a behavioural round-robin model
module tb_rr_arbiter_8;
  localparam int MAX_HOLD = 16;
  typedef struct {
    logic [7:0] grant;
    logic       valid;
    logic [2:0] code;
    logic       chk_code;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] grant;
  logic [2:0] grant_code;
  logic grant_valid;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  bit m_valid = 1'b0;
  bit m_fresh = 1'b1;
  int m_owner = 0;
  int m_last = 7;
  int m_held = 0;
  rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .grant      (grant),
    .grant_code (grant_code),
    .grant_valid(grant_valid)
  );
  always #5 clk = ~clk;
  function automatic int pick(input logic [7:0] r, input int last);
    for (int k = 1; k <= 8; k++)
      if (r[(last + k) % 8]) return (last + k) % 8;
    return -1;
  endfunction
  // Advance the model by one clock edge with the given inputs and queue the response expected after that edge
  task automatic cyc(input logic [7:0] r, input logic rs);
    int w;
    exp_t e;
    @(negedge clk);
    req = r;
    reset = rs;
    w = pick(r, m_last);
    if (rs) begin
      m_valid = 0; m_fresh = 1; m_owner = 0; m_last = 7; m_held = 0;
    end else if (m_valid && r[m_owner] && (MAX_HOLD == 0 || m_held + 1 < MAX_HOLD)) begin
      m_held++;
    end else if (w >= 0) begin
      m_valid = 1; m_fresh = 0; m_owner = w; m_last = w; m_held = 0;
    end else begin
      m_valid = 0;
    end
    e.valid = m_valid;
    e.grant = m_valid ? 8'(1 << m_owner) : 8'h00;
    e.code = 3'(m_owner);
    e.chk_code = m_valid || m_fresh;
    sb.push_back(e);
  endtask
  task automatic repeat_cyc(input logic [7:0] r, input int n);
    for (int i = 0; i < n; i++) cyc(r, 1'b0);
  endtask
  // Monitor: after each edge pop the expected response and compare
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (grant !== e.grant) begin
          errors++;
          $display("FAIL grant t=%0t got %h exp %h", $time, grant, e.grant);
        end
        checks++;
        if (grant_valid !== e.valid) begin
          errors++;
          $display("FAIL grant_valid t=%0t got %b exp %b", $time, grant_valid, e.valid);
        end
        if (e.chk_code) begin
          checks++;
          if (grant_code !== e.code) begin
            errors++;
            $display("FAIL grant_code t=%0t got %0d exp %0d", $time, grant_code, e.code);
          end
        end
      end
    end
  end
  initial begin
    logic [7:0] r;
    cyc(8'h00, 1'b1);
    cyc(8'h00, 1'b1);
    repeat_cyc(8'h00, 5);
    repeat_cyc(8'b1000_0001, 34);
    cyc(8'h00, 1'b1);
    repeat_cyc(8'b0000_0100, 3);
    cyc(8'b0010_0100, 1'b0);
    repeat_cyc(8'b0010_0000, 3);
    repeat_cyc(8'b0000_1000, 40);
    cyc(8'h00, 1'b1);
    repeat_cyc(8'b0100_0000, 2);
    repeat_cyc(8'b0000_0011, 3);
    repeat_cyc(8'b0001_0000, 3);
    cyc(8'hFF, 1'b1);
    repeat_cyc(8'hFF, 20);
    r = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0)
        r = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom & $urandom);
      cyc(r, $urandom_range(0, 199) == 0);
    end
    repeat_cyc(8'h00, 2);
    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Round-robin arbiter sharing one resource among 8 requesters.
- The winner index is registered as a 3-bit code, and a decoder_3_8 instance turns that code into the one-hot grant bus.
- Sits in front of any shared 8-way resource, such as a bus, a display digit or a memory port, in the Decoders project.
- Supports an optional maximum hold time, so no requester can starve the others.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one owner may keep the grant. 0 means unlimited; the grant then ends only when req drops.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous reset, active-high.
- req  input  8  request vector; bit i = requester i wants the resource.
- grant  output  8  one-hot grant. All-zero when grant_valid=0.
- grant_code  output  3  index of the current owner. Meaningful only when grant_valid=1.
- grant_valid  output  1  high while some requester owns the resource.

Behaviour:
- Reset, sampled on the clk edge:
  - state=IDLE, grant_valid=0, grant_code=0, grant=8'h00, hold_cnt=0.
  - Priority pointer last=7, so requester 0 has top priority after reset.
- grant is derived as follows:
  - decoder_3_8(grant_code) AND-gated by grant_valid.
  - Combinational from registers, no added latency, no glitch path from req.
- Round-robin pick:
  - Scan req starting at last+1, incrementing mod 8, wrapping 7->0.
  - The first set bit wins.
  - The previous owner has the lowest priority.
- State IDLE:
  - If req != 0, the winner is registered on the next edge: grant_code=winner, grant_valid=1, last=winner, hold_cnt=0, state=GRANT.
  - Latency from req edge-sampled high to grant high is exactly 1 cycle.
  - If req == 0, stay in IDLE with all outputs 0.
- State GRANT, with owner = grant_code:
  - Hold: req[owner]=1 and (MAX_HOLD==0 or hold_cnt < MAX_HOLD-1). Stay in GRANT and increment hold_cnt. hold_cnt saturates; it does not wrap when MAX_HOLD==0.
  - Release: req[owner]=0.
    - If other requests are pending, re-arbitrate in the same cycle and hand over directly: GRANT->GRANT, new grant_code, hold_cnt=0. There is no idle gap.
    - If no requests are pending, grant_valid=0 and state=IDLE on the next edge.
  - Timeout: req[owner]=1 and hold_cnt==MAX_HOLD-1, so the owner has held for exactly MAX_HOLD cycles.
    - Re-arbitrate with the owner at lowest priority.
    - If the owner is the only requester, it is re-granted with hold_cnt=0. grant stays high continuously in this case.
- Simultaneous events:
  - Release and timeout in the same cycle are treated as release.
  - Requests arriving during GRANT are only sampled at handover.
- Changes to req bits other than the owner's never disturb the current grant.
- Reset mid-grant: grant drops on the same edge, and the pointer returns to 7.
- Width rule: hold_cnt width = clog2(MAX_HOLD+1), minimum 1 bit.

Decomposition:
- Package arb_pkg holds:
  - N_REQ=8 and CODE_W=3.
  - State encoding: IDLE=1'b0, GRANT=1'b1.
  - Function rr_pick(req, last), returning {found, idx[2:0]}.
- Sub-module: decoder_3_8 (code_in=grant_code, code_out -> one-hot source). It is reused unchanged.
- Everything else lives in rr_arbiter_8: the FSM, hold counter and pointer.

Test Plan:
- Reset, then req=8'h00 for 5 cycles -> grant=0, grant_valid=0, grant_code=0 throughout.
- After reset, req=8'b1000_0001 held high:
  - 1 cycle later, grant=8'h01 and grant_code=0.
  - After 16 cycles (MAX_HOLD=16), grant=8'h80 and grant_code=7.
  - 16 cycles after that, grant=8'h01 again.
- Owner 2 with req=8'b0010_0100, then drop req[2]:
  - Next edge: grant=8'h20, grant_code=5, with no cycle where grant_valid=0.
- Only req[3] held for 40 cycles with MAX_HOLD=16 -> grant=8'h08 continuously, grant_valid never drops, and hold_cnt restarts at 16 and 32.
- Wrap-around: owner 6, req=8'b0000_0011 at handover -> next grant=8'h01, not 8'h02.
- Reset asserted while grant=8'h10 -> next edge grant=0. With req=8'hFF held, 1 cycle after reset deasserts, grant=8'h01.
